mc_control_fsm: RTL and testbench

- Multi-cycle MIPS control sequencer that replaces the single-cycle decoder and drives the shared datapath: PC, instruction register (IR), register file, ALU and unified instruction/data memory.
- Steps each instruction through fetch, decode, execute, memory and writeback states, one state per clock.
- Stalls on a memory-ready handshake.
- Sits between the IR opcode/funct fields and every datapath mux and write enable.

---
 rtl/mc_ctrl_pkg.sv | 68 ++++++
 rtl/alu_op_decode.sv | 28 ++
 rtl/mc_control_fsm.sv | 231 +++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control sequencer
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
        S_JR       = 4'd12,
        S_JAL      = 4'd13,
        S_HALT     = 4'd14
    } state_t;

    localparam int RA_REG = 31;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_REG    = 2'b11;

    function automatic logic is_rtype_alu(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_AND) ||
               (funct == FN_NOR) || (funct == FN_SLT);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - OpCode/Funct to ALUOp mapping shared by the execute states
module alu_op_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    output logic [2:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        if (op_code == OP_RTYPE) begin
            case (funct)
                FN_AND:  alu_op = ALU_AND;
                FN_NOR:  alu_op = ALU_NOR;
                FN_SLT:  alu_op = ALU_SLT;
                default: alu_op = ALU_ADD;
            endcase
        end else begin
            case (op_code)
                OP_ANDI: alu_op = ALU_AND;
                OP_BEQ:  alu_op = ALU_SUB;
                default: alu_op = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle MIPS control FSM; MC_CTRL_PERF_CNT_EN adds cycle/instr counters
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemToReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal,
    output logic [3:0] state
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    state_t     state_q;
    state_t     state_d;
    logic       illegal_set;
    logic [2:0] exec_alu_op;
    // The branch decision is made in the datapath via PCWriteCond & Zero.
    logic       zero_unused;

    assign zero_unused = Zero;
    assign state       = state_q;

    alu_op_decode u_alu_op_decode (
        .op_code (OpCode),
        .funct   (Funct),
        .alu_op  (exec_alu_op)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            if (illegal_set) begin
                illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        illegal_set = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = RD_RT;
        MemToReg    = M2R_ALUOUT;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALU_AND;
        PCSource    = PCS_ALU;

        case (state_q)
            S_FETCH: begin
                MemRead  = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                ALUOp    = ALU_ADD;
                IRWrite  = mem_ready;
                PCWrite  = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
                ALUOp   = ALU_ADD;
                case (OpCode)
                    OP_LW, OP_SW:     state_d = S_MEM_ADDR;
                    OP_BEQ:           state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI: state_d = S_I_EXEC;
                    OP_J:             state_d = S_JUMP;
                    OP_JAL:           state_d = S_JAL;
                    OP_RTYPE: begin
                        if (is_rtype_alu(Funct)) begin
                            state_d = S_R_EXEC;
                        end else if (Funct == FN_JR) begin
                            state_d = S_JR;
                        end else begin
                            state_d     = S_HALT;
                            illegal_set = 1'b1;
                        end
                    end
                    default: begin
                        state_d     = S_HALT;
                        illegal_set = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALU_ADD;
                state_d = (OpCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                RegDst   = RD_RT;
                MemToReg = M2R_MDR;
                state_d  = S_FETCH;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_B;
                ALUOp   = exec_alu_op;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = RD_RD;
                MemToReg = M2R_ALUOUT;
                state_d  = S_FETCH;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = exec_alu_op;
                state_d = S_I_WB;
            end
            S_I_WB: begin
                RegWrite = 1'b1;
                RegDst   = RD_RT;
                MemToReg = M2R_ALUOUT;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_B;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCS_ALUOUT;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCS_JUMP;
                state_d  = S_FETCH;
            end
            S_JR: begin
                PCWrite  = 1'b1;
                PCSource = PCS_REG;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4 here, so the link value is the current PC.
                RegWrite = 1'b1;
                RegDst   = RD_RA;
                MemToReg = M2R_PC;
                PCWrite  = 1'b1;
                PCSource = PCS_JUMP;
                state_d  = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegDst      = RD_RT;
            MemToReg    = M2R_ALUOUT;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = SRCB_B;
            ALUOp       = ALU_AND;
            PCSource    = PCS_ALU;
            illegal_set = 1'b0;
        end
    end

`ifdef MC_CTRL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else if (state_q != S_HALT) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if ((state_q != S_FETCH) && (state_d == S_FETCH)) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - directed self-checking bench for mc_control_fsm
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] OpCode = 6'd0;
    logic [5:0] Funct = 6'd0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0] RegDst, MemToReg;
    logic       RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic       illegal;
    logic [3:0] state;
`ifdef MC_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .OpCode      (OpCode),
        .Funct       (Funct),
        .Zero        (Zero),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegDst      (RegDst),
        .MemToReg    (MemToReg),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .illegal     (illegal),
        .state       (state)
`ifdef MC_CTRL_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
`endif
    );

    // {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst,
    //  MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource}
    wire [22:0] obs = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                       RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    localparam logic [22:0] E_ZERO       = {4'd0,  6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [22:0] E_FETCH_RDY  = {4'd0,  6'b100101, 2'b00, 2'b00, 2'b00, 2'b01, 3'b010, 2'b00};
    localparam logic [22:0] E_FETCH_WAIT = {4'd0,  6'b000100, 2'b00, 2'b00, 2'b00, 2'b01, 3'b010, 2'b00};
    localparam logic [22:0] E_DEC        = {4'd1,  6'b000000, 2'b00, 2'b00, 2'b00, 2'b11, 3'b010, 2'b00};
    localparam logic [22:0] E_MADDR      = {4'd2,  6'b000000, 2'b00, 2'b00, 2'b01, 2'b10, 3'b010, 2'b00};
    localparam logic [22:0] E_MRD        = {4'd3,  6'b001100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [22:0] E_MWB        = {4'd4,  6'b000000, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 2'b00};
    localparam logic [22:0] E_MWR        = {4'd5,  6'b001010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [22:0] E_REXEC_ADD  = {4'd6,  6'b000000, 2'b00, 2'b00, 2'b01, 2'b00, 3'b010, 2'b00};
    localparam logic [22:0] E_RWB        = {4'd7,  6'b000000, 2'b01, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00};
    localparam logic [22:0] E_BR         = {4'd8,  6'b010000, 2'b00, 2'b00, 2'b01, 2'b00, 3'b110, 2'b01};
    localparam logic [22:0] E_JR         = {4'd12, 6'b100000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11};
    localparam logic [22:0] E_JAL        = {4'd13, 6'b100000, 2'b10, 2'b10, 2'b10, 2'b00, 3'b000, 2'b10};
    localparam logic [22:0] E_HALT       = {4'd14, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        mem_ready = 1'b1;
        reset = 1'b1;
        step();
        step();
        vectors++;
        if (obs !== E_ZERO) begin
            errors++;
            $display("FAIL reset_outputs got %h want %h", obs, E_ZERO);
        end
        vectors++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_illegal got %b want 0", illegal);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (obs !== E_FETCH_RDY) begin
            errors++;
            $display("FAIL reset_release_fetch got %h want %h", obs, E_FETCH_RDY);
        end
    endtask

    task automatic test_add();
        logic [22:0] seq [4];
        seq = '{E_FETCH_RDY, E_DEC, E_REXEC_ADD, E_RWB};
        apply_reset();
        mem_ready = 1'b1;
        OpCode = 6'b000000;
        Funct = 6'b100000;
        #1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (obs !== seq[i]) begin
                errors++;
                $display("FAIL add_cycle%0d got %h want %h", i, obs, seq[i]);
            end
            step();
        end
        vectors++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL add_return got %0d want 0", state);
        end
    endtask

    task automatic test_lw_stall();
        logic [22:0] seq [10];
        logic [1:0]  rdy [10];
        seq = '{E_FETCH_WAIT, E_FETCH_WAIT, E_FETCH_RDY, E_DEC, E_MADDR,
                E_MRD, E_MRD, E_MRD, E_MRD, E_MWB};
        rdy = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
        apply_reset();
        OpCode = 6'b100011;
        Funct = 6'b000000;
        for (int i = 0; i < 10; i++) begin
            mem_ready = rdy[i][0];
            #1;
            vectors++;
            if (obs !== seq[i]) begin
                errors++;
                $display("FAIL lw_cycle%0d got %h want %h", i, obs, seq[i]);
            end
            step();
        end
        vectors++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL lw_return got %0d want 0", state);
        end
    endtask

    task automatic test_beq();
        mem_ready = 1'b1;
        OpCode = 6'b000100;
        for (int z = 0; z < 2; z++) begin
            apply_reset();
            Zero = z[0];
            step();
            step();
            vectors++;
            if (obs !== E_BR) begin
                errors++;
                $display("FAIL beq_zero%0d_branch got %h want %h", z, obs, E_BR);
            end
            step();
            vectors++;
            if (obs !== E_FETCH_RDY) begin
                errors++;
                $display("FAIL beq_zero%0d_return got %h want %h", z, obs, E_FETCH_RDY);
            end
        end
        Zero = 1'b0;
    endtask

    task automatic test_jumps();
        apply_reset();
        mem_ready = 1'b1;
        OpCode = 6'b000011;
        step();
        step();
        vectors++;
        if (obs !== E_JAL) begin
            errors++;
            $display("FAIL jal_state got %h want %h", obs, E_JAL);
        end
        OpCode = 6'b000000;
        Funct = 6'b001000;
        step();
        step();
        step();
        vectors++;
        if (obs !== E_JR) begin
            errors++;
            $display("FAIL jr_state got %h want %h", obs, E_JR);
        end
        step();
        vectors++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL jr_return got %0d want 0", state);
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        mem_ready = 1'b1;
        OpCode = 6'b111111;
        step();
        vectors++;
        if (obs !== E_DEC || illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_decode got %h/%b want %h/0", obs, illegal, E_DEC);
        end
        step();
        OpCode = 6'b000000;
        Funct = 6'b100000;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs !== E_HALT || illegal !== 1'b1) begin
                errors++;
                $display("FAIL illegal_halt%0d got %h/%b want %h/1", i, obs, illegal, E_HALT);
            end
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        vectors++;
        if (state !== 4'd0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_cleared got %0d/%b want 0/0", state, illegal);
        end
    endtask

    task automatic test_reset_in_memwr();
        apply_reset();
        mem_ready = 1'b1;
        OpCode = 6'b101011;
        step();
        step();
        mem_ready = 1'b0;
        step();
        vectors++;
        if (obs !== E_MWR) begin
            errors++;
            $display("FAIL sw_memwr got %h want %h", obs, E_MWR);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (MemWrite !== 1'b0 || state !== 4'd5) begin
            errors++;
            $display("FAIL sw_reset_memwrite got %b/%0d want 0/5", MemWrite, state);
        end
        step();
        vectors++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL sw_reset_state got %0d want 0", state);
        end
        reset = 1'b0;
    endtask

`ifdef MC_CTRL_PERF_CNT_EN
    task automatic test_perf_cnt();
        apply_reset();
        mem_ready = 1'b1;
        OpCode = 6'b000000;
        Funct = 6'b100000;
        for (int i = 0; i < 12; i++) begin
            step();
        end
        vectors++;
        if (instr_cnt !== 32'd3 || cycle_cnt !== 32'd12) begin
            errors++;
            $display("FAIL perf_cnt got instr=%0d cycle=%0d want 3/12", instr_cnt, cycle_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_lw_stall();
        test_beq();
        test_jumps();
        test_illegal();
        test_reset_in_memwr();
`ifdef MC_CTRL_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
